// File: rtl/scoot_arena.sv
`default_nettype none
// ============================================================================
// Module   : scoot_arena
// Purpose  : Grid-world arena for scoot-bot controllers. It holds the food map
//            and the bot position, drives the neighbour sensors and runs
//            fixed-length fitness runs.
// Revision : 1.0
// ============================================================================
module scoot_arena #(
    parameter int                WIDTH       = 10,
    parameter int                HEIGHT      = 10,
    parameter int                NUM_STEPS   = 100,
    parameter int                STEP_CYCLES = 8,
    parameter bit                WRAP        = 1'b1,
    parameter logic [HEIGHT-1:0] ROW_PATTERN = HEIGHT'(10'b0010101001),
    localparam int               XW          = $clog2(WIDTH),
    localparam int               YW          = $clog2(HEIGHT),
    localparam int               SW          = $clog2(WIDTH*HEIGHT+1),
    localparam int               NW          = $clog2(NUM_STEPS+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          load_en,
    input  logic [XW-1:0] load_x,
    input  logic [YW-1:0] load_y,
    input  logic          load_val,
    input  logic          m_up,
    input  logic          m_right,
    input  logic          m_down,
    input  logic          m_left,
    output logic          l_up,
    output logic          l_right,
    output logic          l_down,
    output logic          l_left,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [SW-1:0] score,
    output logic [NW-1:0] steps,
    output logic          pickup,
    output logic          busy,
    output logic          done
);

    localparam int          CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [XW-1:0] c_CX   = XW'(WIDTH / 2);
    localparam logic [YW-1:0] c_CY   = YW'(HEIGHT / 2);
    localparam logic [XW-1:0] c_XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] c_YMAX = YW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PICK = 3'd1,
        S_WAIT = 3'd2,
        S_MOVE = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [HEIGHT-1:0]   r_map [WIDTH];
    logic [XW-1:0]       r_posX;
    logic [YW-1:0]       r_posY;
    logic [SW-1:0]       r_score;
    logic [NW-1:0]       r_steps;
    logic [CW-1:0]       r_waitCnt;
    logic                r_mUp, r_mRight, r_mDown, r_mLeft;
    logic                r_lUp, r_lRight, r_lDown, r_lLeft;

    logic                w_atLeft, w_atRight, w_atBottom, w_atTop;
    logic [XW-1:0]       w_xInc, w_xDec, w_nextX;
    logic [YW-1:0]       w_yInc, w_yDec, w_nextY;
    logic                w_cellHere, w_waitLast, w_lastStep, w_loadOk;
    logic                w_senseUp, w_senseRight, w_senseDown, w_senseLeft;

    // Neighbour coordinates always wrap; walled mode masks or clamps them.
    assign w_atLeft   = (r_posX == '0);
    assign w_atRight  = (r_posX == c_XMAX);
    assign w_atBottom = (r_posY == '0);
    assign w_atTop    = (r_posY == c_YMAX);
    assign w_xInc     = w_atRight  ? '0     : r_posX + XW'(1);
    assign w_xDec     = w_atLeft   ? c_XMAX : r_posX - XW'(1);
    assign w_yInc     = w_atTop    ? '0     : r_posY + YW'(1);
    assign w_yDec     = w_atBottom ? c_YMAX : r_posY - YW'(1);

    assign w_cellHere   = r_map[r_posX][r_posY];
    assign w_senseUp    = (WRAP || !w_atTop)    && r_map[r_posX][w_yInc];
    assign w_senseDown  = (WRAP || !w_atBottom) && r_map[r_posX][w_yDec];
    assign w_senseRight = (WRAP || !w_atRight)  && r_map[w_xInc][r_posY];
    assign w_senseLeft  = (WRAP || !w_atLeft)   && r_map[w_xDec][r_posY];

    assign w_waitLast = (r_waitCnt == CW'(STEP_CYCLES - 1));
    assign w_lastStep = (r_steps == NW'(NUM_STEPS - 1));
    assign w_loadOk   = load_en && (int'(load_x) < WIDTH) && (int'(load_y) < HEIGHT);

    // Opposing commands cancel; at a wall the position simply holds.
    always_comb begin
        w_nextX = r_posX;
        w_nextY = r_posY;
        if (r_mRight && !r_mLeft) begin
            w_nextX = (WRAP || !w_atRight) ? w_xInc : r_posX;
        end else if (r_mLeft && !r_mRight) begin
            w_nextX = (WRAP || !w_atLeft) ? w_xDec : r_posX;
        end
        if (r_mUp && !r_mDown) begin
            w_nextY = (WRAP || !w_atTop) ? w_yInc : r_posY;
        end else if (r_mDown && !r_mUp) begin
            w_nextY = (WRAP || !w_atBottom) ? w_yDec : r_posY;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_nextState = S_PICK;
            S_PICK:         w_nextState = S_WAIT;
            S_WAIT:         if (w_waitLast) w_nextState = S_MOVE;
            S_MOVE:         w_nextState = w_lastStep ? S_DONE : S_PICK;
            default:        w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_map[i] <= ROW_PATTERN;
            end
            r_posX    <= c_CX;
            r_posY    <= c_CY;
            r_score   <= '0;
            r_steps   <= '0;
            r_waitCnt <= '0;
            r_mUp     <= 1'b0;
            r_mRight  <= 1'b0;
            r_mDown   <= 1'b0;
            r_mLeft   <= 1'b0;
            r_lUp     <= 1'b0;
            r_lRight  <= 1'b0;
            r_lDown   <= 1'b0;
            r_lLeft   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_loadOk) begin
                        r_map[load_x][load_y] <= load_val;
                    end
                    if (start) begin
                        r_posX  <= c_CX;
                        r_posY  <= c_CY;
                        r_score <= '0;
                        r_steps <= '0;
                    end
                end
                S_PICK: begin
                    if (w_cellHere) begin
                        r_map[r_posX][r_posY] <= 1'b0;
                        r_score               <= r_score + SW'(1);
                    end
                    // Neighbours never coincide with the bot cell, so the
                    // current map already equals the post-pickup map here.
                    r_lUp     <= w_senseUp;
                    r_lRight  <= w_senseRight;
                    r_lDown   <= w_senseDown;
                    r_lLeft   <= w_senseLeft;
                    r_waitCnt <= '0;
                end
                S_WAIT: begin
                    r_waitCnt <= r_waitCnt + CW'(1);
                    if (w_waitLast) begin
                        r_mUp    <= m_up;
                        r_mRight <= m_right;
                        r_mDown  <= m_down;
                        r_mLeft  <= m_left;
                    end
                end
                S_MOVE: begin
                    r_posX  <= w_nextX;
                    r_posY  <= w_nextY;
                    r_steps <= r_steps + NW'(1);
                end
                default: ;
            endcase
        end
    end

    assign l_up    = r_lUp;
    assign l_right = r_lRight;
    assign l_down  = r_lDown;
    assign l_left  = r_lLeft;
    assign pos_x   = r_posX;
    assign pos_y   = r_posY;
    assign score   = r_score;
    assign steps   = r_steps;
    assign pickup  = (r_state == S_PICK) && w_cellHere;
    assign busy    = (r_state == S_PICK) || (r_state == S_WAIT) || (r_state == S_MOVE);
    assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire
